// File: rtl/sort_result_streamer.sv
// Snapshots the four sorted registers on sort_done and streams them out one
// element per valid/ready beat, with an ordering check and a sticky overrun flag.
module sort_result_streamer #(
  parameter int DATA_WIDTH = 4,
  parameter bit ASCENDING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sort_done,
  input  logic [DATA_WIDTH-1:0] first_reg,
  input  logic [DATA_WIDTH-1:0] second_reg,
  input  logic [DATA_WIDTH-1:0] third_reg,
  input  logic [DATA_WIDTH-1:0] fourth_reg,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_index,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  stream_done,
  output logic                  order_error,
  output logic                  overrun
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]            state;
  logic [1:0]            idx;
  logic [DATA_WIDTH-1:0] snap [4];
  logic                  hs;
  logic                  final_hs;
  logic                  capture;

  function automatic logic order_bad(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b,
                                     input logic [DATA_WIDTH-1:0] c,
                                     input logic [DATA_WIDTH-1:0] d);
    if (ASCENDING)
      return (a > b) || (b > c) || (c > d);
    else
      return (a < b) || (b < c) || (c < d);
  endfunction

  assign hs       = (state == S_STREAM) && out_ready;
  assign final_hs = hs && (idx == 2'd3);
  // A new frame is taken while idle, or on the edge that retires the last beat.
  assign capture  = sort_done && ((state == S_IDLE) || final_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      stream_done <= 1'b0;
      order_error <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < 4; k++) snap[k] <= '0;
    end else begin
      stream_done <= final_hs;
      if (sort_done && !capture) overrun <= 1'b1;
      if (capture) begin
        snap[0]     <= first_reg;
        snap[1]     <= second_reg;
        snap[2]     <= third_reg;
        snap[3]     <= fourth_reg;
        order_error <= order_bad(first_reg, second_reg, third_reg, fourth_reg);
        idx         <= 2'd0;
        state       <= S_STREAM;
      end else if (final_hs) begin
        idx   <= 2'd0;
        state <= S_IDLE;
      end else if (hs) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Outputs decode registered state only; nothing passes straight from inputs.
  assign out_valid = (state == S_STREAM);
  assign busy      = (state == S_STREAM);
  assign out_index = (state == S_STREAM) ? idx : 2'd0;
  assign out_data  = (state == S_STREAM) ? snap[idx] : '0;
  assign out_last  = (state == S_STREAM) && (idx == 2'd3);

endmodule
